divsqrt_postproc_pipe: RTL and testbench
========================================

DIVSQRT_POSTPROC_PIPE -- requirements
Module: divsqrt_postproc_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 64, meaning integer result width (32 or 64).
REQ-002 SHALL provide parameter DIVb, default 64, meaning quotient fraction bits; residual width is DIVb+4.
REQ-003 SHALL provide parameter LOGR, default 1, meaning log2 of the radix (1, 2 or 3).
REQ-004 SHALL provide parameter SHW, default 7, meaning normalization shift amount width.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- InValid  in  1  input beat valid.
- InReady  out  1  input beat accepted when InValid & InReady.
- WS, WC  in  DIVb+4  redundant residual (sum, carry).
- D  in  DIVb+4  divisor.
- U, UM  in  DIVb+1  quotient candidates U and U-1.
- A  in  XLEN  original dividend.
- SqrtIn, RemOp, NegQuot, As, BZero, ALTB, W64, Special  in  1 each  mode and special-case flags.
- ShAmt  in  SHW  precomputed right-shift for integer normalization.
- OutValid  out  1  result valid.
- OutReady  in  1  result accepted when OutValid & OutReady.
- Qm  out  DIVb+1  selected floating-point quotient (shifted left 1 for sqrt).
- Sticky  out  1  inexact flag.
- IntResult  out  XLEN  integer quotient or remainder.

Function
REQ-006 SHALL be a two-stage pipeline (S1, S2); latency from accepted input to OutValid is exactly 2 cycles with no stalls.
REQ-007 S1 SHALL register Sum = WS+WC (mod 2^(DIVb+4)), NegSticky = Sum[DIVb+3], plus D, the selected U/UM, A, ShAmt and all flags.
REQ-008 S1 selected quotient SHALL be UM when NegSticky=1, else U.
REQ-009 Sticky SHALL be (Sum != 0) & ~(Special & SqrtIn), computed in S1 and carried to S2.
REQ-010 Qm SHALL be the selected quotient, shifted left by 1 when SqrtIn=1.
REQ-011 S2 remainder: W = Sum arithmetically shifted right by LOGR; add D when NegSticky=1; two's-complement negate when As=1.
REQ-012 S2 quotient: {3'b000, selected quotient}, two's-complement negated when NegQuot=1.
REQ-013 S2 SHALL select the remainder when RemOp=1, else the quotient, then arithmetic-shift right by ShAmt and truncate to XLEN.
REQ-014 Special-case overrides:
- BZero=1: result = A if RemOp=1, else all ones.
- else ALTB=1: result = A if RemOp=1, else 0.
- BZero has priority over ALTB.
REQ-015 When XLEN=64 and W64=1, IntResult SHALL be bits [31:0] sign-extended from bit 31; W64 is ignored when XLEN=32.
REQ-016 Stage handshake:
- S2Ready = ~S2Valid | OutReady.
- InReady = ~S1Valid | S2Ready.
- S1 advances into S2 only when S2Ready.
REQ-017 While OutValid=1 and OutReady=0, all outputs SHALL hold stable.
REQ-018 Simultaneous accept and drain SHALL sustain one result per cycle with no bubble.
REQ-019 flush=1 SHALL clear both stage valid bits on the next edge and drop any input offered that cycle; data registers need not clear; flush overrides InValid.
REQ-020 Output payloads SHALL be registered (driven from S2 flops), not combinational from inputs.

Reset
REQ-021 While reset=1, all of S1Valid, S2Valid, OutValid, Qm, Sticky and IntResult SHALL be 0 immediately, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight beats; no result for them is ever produced.
REQ-023 After reset deassertion, InReady SHALL be 1 on the first cycle.

Verification
REQ-024 XLEN=32: BZero=1, RemOp=0 -> IntResult=0xFFFFFFFF after 2 cycles; RemOp=1 with A=0x1234 -> 0x00001234.
REQ-025 WS=0, WC=0 -> Sticky=0 and Qm=U; WS=0, WC=all ones -> NegSticky path, Qm=UM, Sticky=1.
REQ-026 XLEN=64: pre-extension result 0x0000_0000_8000_0000 with W64=1 -> IntResult=0xFFFF_FFFF_8000_0000; with W64=0 -> unchanged.
REQ-027 Back-pressure:
- Stimulus: OutReady=0 for 3 cycles, 3 back-to-back inputs.
- Response: first two accepted; InReady=0 on the third; outputs stable; on OutReady=1, results emerge in order, one per cycle.
REQ-028 flush with both stages valid -> OutValid=0 the next cycle and no stale result ever appears; reset pulse mid-stream -> all outputs 0 asynchronously.
REQ-029 Random streams vs a reference model (WS+WC residual, random flags, random OutReady) -> bit-exact Qm, Sticky, IntResult, in order, no loss or duplication.

Source files
------------

// File: rtl/divsqrt_postproc_pipe.sv
// rtl/divsqrt_postproc_pipe.sv - two-stage divide/sqrt post-processing: residual sign, quotient select, integer result
module divsqrt_postproc_pipe #(
    parameter int XLEN = 64,
    parameter int DIVb = 64,
    parameter int LOGR = 1,
    parameter int SHW  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DIVb+3:0]   WS,
    input  logic [DIVb+3:0]   WC,
    input  logic [DIVb+3:0]   D,
    input  logic [DIVb:0]     U,
    input  logic [DIVb:0]     UM,
    input  logic [XLEN-1:0]   A,
    input  logic              SqrtIn,
    input  logic              RemOp,
    input  logic              NegQuot,
    input  logic              As,
    input  logic              BZero,
    input  logic              ALTB,
    input  logic              W64,
    input  logic              Special,
    input  logic [SHW-1:0]    ShAmt,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DIVb:0]     Qm,
    output logic              Sticky,
    output logic [XLEN-1:0]   IntResult
);
    localparam int RW = DIVb + 4;

    logic            r_s1_valid, r_s2_valid;
    logic [RW-1:0]   r_s1_sum, r_s1_d;
    logic [DIVb:0]   r_s1_q;
    logic [XLEN-1:0] r_s1_a;
    logic [SHW-1:0]  r_s1_shamt;
    logic            r_s1_neg, r_s1_sticky, r_s1_sqrt, r_s1_remop, r_s1_negquot;
    logic            r_s1_as, r_s1_bzero, r_s1_altb, r_s1_w64;
    logic [DIVb:0]   r_qm;
    logic            r_sticky;
    logic [XLEN-1:0] r_int;

    logic            w_s2_ready, w_in_fire, w_s1_fire;
    logic [RW-1:0]   w_sum;
    logic            w_neg, w_sticky;
    logic [DIVb:0]   w_q, w_qm;
    logic signed [RW-1:0] w_rem, w_quo, w_sel;
    logic [XLEN-1:0] w_int;

    assign w_s2_ready = ~r_s2_valid | OutReady;
    assign InReady    = ~r_s1_valid | w_s2_ready;
    assign w_in_fire  = InValid & InReady & ~flush;
    assign w_s1_fire  = r_s1_valid & w_s2_ready;

    assign w_sum    = WS + WC;
    assign w_neg    = w_sum[RW-1];
    assign w_q      = w_neg ? UM : U;
    assign w_sticky = (w_sum != '0) & ~(Special & SqrtIn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (InReady)    r_s1_valid <= InValid;
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
        end
    end

    // Stage-1 payload needs no reset: it is only observed behind r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_sum     <= w_sum;
            r_s1_neg     <= w_neg;
            r_s1_d       <= D;
            r_s1_q       <= w_q;
            r_s1_a       <= A;
            r_s1_shamt   <= ShAmt;
            r_s1_sticky  <= w_sticky;
            r_s1_sqrt    <= SqrtIn;
            r_s1_remop   <= RemOp;
            r_s1_negquot <= NegQuot;
            r_s1_as      <= As;
            r_s1_bzero   <= BZero;
            r_s1_altb    <= ALTB;
            r_s1_w64     <= W64;
        end
    end

    assign w_qm = r_s1_sqrt ? {r_s1_q[DIVb-1:0], 1'b0} : r_s1_q;

    always_comb begin
        w_rem = $signed(r_s1_sum) >>> LOGR;
        if (r_s1_neg) w_rem = w_rem + $signed(r_s1_d);
        if (r_s1_as)  w_rem = -w_rem;
        w_quo = $signed({3'b000, r_s1_q});
        if (r_s1_negquot) w_quo = -w_quo;
        w_sel = r_s1_remop ? w_rem : w_quo;
        w_int = XLEN'(w_sel >>> r_s1_shamt);
        if (r_s1_bzero)     w_int = r_s1_remop ? r_s1_a : '1;
        else if (r_s1_altb) w_int = r_s1_remop ? r_s1_a : '0;
        // 32-bit word ops on a 64-bit machine return a sign-extended low word.
        if (XLEN == 64 && r_s1_w64) w_int = XLEN'($signed(w_int[31:0]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_qm     <= '0;
            r_sticky <= 1'b0;
            r_int    <= '0;
        end else if (w_s1_fire) begin
            r_qm     <= w_qm;
            r_sticky <= r_s1_sticky;
            r_int    <= w_int;
        end
    end

    assign OutValid  = r_s2_valid;
    assign Qm        = r_qm;
    assign Sticky    = r_sticky;
    assign IntResult = r_int;
endmodule

// File: tb/tb_divsqrt_postproc_pipe.sv
// tb/tb_divsqrt_postproc_pipe.sv - scoreboard bench for divsqrt_postproc_pipe
module tb_divsqrt_postproc_pipe;
    typedef struct packed {
        logic [67:0] ws, wc, d;
        logic [64:0] u, um;
        logic [63:0] a;
        logic sqrt, remop, negquot, as_, bzero, altb, w64, special;
        logic [6:0]  shamt;
    } beat_t;
    typedef struct packed {
        logic [64:0] qm;
        logic        sticky;
        logic [63:0] ir;
    } exp_t;

    logic clk = 1'b0;
    logic reset, flush, InValid, OutReady;
    logic InReady, OutValid, Sticky;
    logic [64:0] Qm;
    logic [63:0] IntResult;
    beat_t b;
    exp_t  sb[$];
    int checks = 0, failures = 0;
    logic rnd_mode = 1'b0;

    divsqrt_postproc_pipe #(.XLEN(64), .DIVb(64), .LOGR(1), .SHW(7)) dut (
        .clk(clk), .reset(reset), .flush(flush), .InValid(InValid), .InReady(InReady),
        .WS(b.ws), .WC(b.wc), .D(b.d), .U(b.u), .UM(b.um), .A(b.a),
        .SqrtIn(b.sqrt), .RemOp(b.remop), .NegQuot(b.negquot), .As(b.as_),
        .BZero(b.bzero), .ALTB(b.altb), .W64(b.w64), .Special(b.special),
        .ShAmt(b.shamt), .OutValid(OutValid), .OutReady(OutReady),
        .Qm(Qm), .Sticky(Sticky), .IntResult(IntResult)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input beat_t x);
        exp_t m;
        logic [67:0] sum;
        logic neg;
        logic [64:0] q;
        logic signed [67:0] rem, quo, sel, sh;
        logic [63:0] r;
        sum = x.ws + x.wc;
        neg = sum[67];
        q = neg ? x.um : x.u;
        m.qm = x.sqrt ? {q[63:0], 1'b0} : q;
        m.sticky = (sum != 68'd0) && !(x.special && x.sqrt);
        rem = {sum[67], sum[67:1]};
        if (neg) rem = rem + $signed(x.d);
        if (x.as_) rem = 68'd0 - rem;
        quo = {3'b000, q};
        if (x.negquot) quo = 68'd0 - quo;
        sel = x.remop ? rem : quo;
        sh = sel >>> x.shamt;
        r = sh[63:0];
        if (x.bzero) r = x.remop ? x.a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (x.altb) r = x.remop ? x.a : 64'd0;
        if (x.w64) r = {{32{r[31]}}, r[31:0]};
        m.ir = r;
        return m;
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (OutValid && OutReady) begin
                chk("out_expected", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_qm", 128'(Qm), 128'(e.qm));
                    chk("sb_sticky", 128'(Sticky), 128'(e.sticky));
                    chk("sb_int", 128'(IntResult), 128'(e.ir));
                end
            end
            if (flush) sb.delete();
            else if (InValid && InReady) sb.push_back(model(b));
        end
    end

    always @(posedge clk) if (rnd_mode) begin
        #1 OutReady = 1'($urandom_range(0, 1));
    end

    function automatic beat_t zero_beat();
        beat_t z;
        z = '0;
        return z;
    endfunction

    task automatic send(input beat_t x);
        logic acc;
        int n;
        b = x;
        InValid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = InReady && !flush;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 128'(acc), 128'd1);
        InValid = 1'b0;
    endtask

    task automatic send_lat(input beat_t x, input string tag, input logic [63:0] exp_ir);
        send(x);
        @(negedge clk);
        chk({tag, "_lat1"}, 128'(OutValid), 128'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 128'(OutValid), 128'd1);
        chk(tag, 128'(IntResult), 128'(exp_ir));
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t rand_beat();
        beat_t x;
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom}; x.ws = t[67:0];
        t = {$urandom, $urandom, $urandom}; x.wc = t[67:0];
        t = {$urandom, $urandom, $urandom}; x.d  = t[67:0];
        t = {$urandom, $urandom, $urandom}; x.u  = t[64:0];
        t = {$urandom, $urandom, $urandom}; x.um = t[64:0];
        x.a = {$urandom, $urandom};
        x.sqrt    = 1'($urandom_range(0, 1));
        x.remop   = 1'($urandom_range(0, 1));
        x.negquot = 1'($urandom_range(0, 1));
        x.as_     = 1'($urandom_range(0, 1));
        x.bzero   = ($urandom_range(0, 7) == 0);
        x.altb    = ($urandom_range(0, 7) == 0);
        x.w64     = 1'($urandom_range(0, 1));
        x.special = 1'($urandom_range(0, 1));
        x.shamt   = 7'($urandom_range(0, 70));
        return x;
    endfunction

    initial begin
        beat_t x, b1, b2, b3;
        exp_t e1;
        reset = 1'b0; flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        b = zero_beat();
        #1 reset = 1'b1;
        #2;
        chk("rst_outvalid", 128'(OutValid), 128'd0);
        chk("rst_qm", 128'(Qm), 128'd0);
        chk("rst_sticky", 128'(Sticky), 128'd0);
        chk("rst_int", 128'(IntResult), 128'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_inready", 128'(InReady), 128'd1);
        @(posedge clk); #1;

        x = zero_beat(); x.bzero = 1'b1;
        send_lat(x, "bzero_quo", 64'hFFFF_FFFF_FFFF_FFFF);
        x.remop = 1'b1; x.a = 64'h1234;
        send_lat(x, "bzero_rem", 64'h1234);
        x = zero_beat(); x.altb = 1'b1; x.a = 64'h55;
        send_lat(x, "altb_quo", 64'h0);
        x.bzero = 1'b1;
        send_lat(x, "bzero_prio", 64'hFFFF_FFFF_FFFF_FFFF);

        x = zero_beat(); x.u = 65'h5; x.um = 65'h4;
        send_lat(x, "zero_res", 64'h5);
        chk("zero_res_qm", 128'(Qm), 128'h5);
        chk("zero_res_sticky", 128'(Sticky), 128'd0);
        x.wc = '1;
        send(x);
        @(negedge clk); @(negedge clk);
        chk("neg_res_qm", 128'(Qm), 128'h4);
        chk("neg_res_sticky", 128'(Sticky), 128'd1);
        @(posedge clk); #1;

        x = zero_beat(); x.u = 65'h8000_0000; x.w64 = 1'b1;
        send_lat(x, "w64_ext", 64'hFFFF_FFFF_8000_0000);
        x.w64 = 1'b0;
        send_lat(x, "w64_off", 64'h0000_0000_8000_0000);

        // Back-pressure: third beat must stall while both stages are full.
        b1 = zero_beat(); b1.u = 65'h11;
        b2 = zero_beat(); b2.u = 65'h22;
        b3 = zero_beat(); b3.u = 65'h33;
        e1 = model(b1);
        OutReady = 1'b0;
        send(b1);
        send(b2);
        b = b3; InValid = 1'b1;
        @(negedge clk);
        chk("bp_inready0", 128'(InReady), 128'd0);
        chk("bp_outvalid", 128'(OutValid), 128'd1);
        chk("bp_hold1", 128'(IntResult), 128'(e1.ir));
        @(negedge clk);
        chk("bp_inready1", 128'(InReady), 128'd0);
        chk("bp_hold2", 128'(IntResult), 128'(e1.ir));
        @(posedge clk); #1 OutReady = 1'b1;
        @(negedge clk);
        chk("bp_accept3", 128'(InReady), 128'd1);
        @(posedge clk); #1 InValid = 1'b0;
        @(negedge clk);
        chk("bp_stream2", 128'(OutValid), 128'd1);
        @(negedge clk);
        chk("bp_stream3", 128'(OutValid), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_empty", 128'(OutValid), 128'd0);
        @(posedge clk); #1;

        // Flush with both stages full plus an input offered the same cycle.
        OutReady = 1'b0;
        send(b1);
        send(b2);
        b = b3; InValid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_outvalid", 128'(OutValid), 128'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a cycle.
        OutReady = 1'b0;
        send(b1);
        send(b2);
        #2 reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_outvalid", 128'(OutValid), 128'd0);
        chk("mid_rst_qm", 128'(Qm), 128'd0);
        chk("mid_rst_int", 128'(IntResult), 128'd0);
        @(posedge clk); #1 reset = 1'b0; OutReady = 1'b1;
        @(negedge clk);
        chk("mid_rst_inready", 128'(InReady), 128'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_noout", 128'(OutValid), 128'd0);
        end
        @(posedge clk); #1;

        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end else begin
                send(rand_beat());
            end
        end
        @(posedge clk); #2;
        rnd_mode = 1'b0; OutReady = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
